// File: rtl/mic_pkg.sv
// Shared constants, FSM state type and byte-extraction helper for the mic packet sender.
package mic_pkg;
  localparam int unsigned ULAW_W = 8;
  localparam int unsigned MIC_W  = 4 * ULAW_W;

  localparam logic [ULAW_W-1:0] HDR_SAMPLE_DEF = 8'hC7;
  localparam logic [ULAW_W-1:0] HDR_END_DEF    = 8'hC8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_END
  } tx_state_e;

  // idx 0 selects the oldest sample, held in the top byte of the word.
  function automatic logic [ULAW_W-1:0] ulaw_byte(input logic [MIC_W-1:0] word,
                                                  input logic [1:0]       idx);
    logic [MIC_W-1:0] sh;
    sh = word << (ULAW_W * idx);
    return sh[MIC_W-1 -: ULAW_W];
  endfunction
endpackage

// File: rtl/mic_word_fifo.sv
// Synchronous FIFO for mic words; push is ignored when full, pop when empty.
module mic_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/mic_packet_sender.sv
// Buffers packed u-law mic words and streams them as header+4-byte packets,
// closing a recording with a single end marker once all buffered data is sent.
module mic_packet_sender
  import mic_pkg::*;
#(
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [ULAW_W-1:0]  HDR_SAMPLE = HDR_SAMPLE_DEF,
  parameter logic [ULAW_W-1:0]  HDR_END    = HDR_END_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MIC_W-1:0]              mic_data,
  input  logic                          mic_data_valid,
  output logic                          mic_data_retrieved,
  input  logic                          record_stop,
  output logic [ULAW_W-1:0]             tx_byte,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);
  logic [MIC_W-1:0] fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             have_word;
  tx_state_e        state;
  logic [1:0]       idx;
  logic [MIC_W-1:0] word;
  logic             stop_pending;
  logic [5:0]       wait_cnt;

  // The previous-cycle guard stops a second acknowledge while upstream is still dropping valid.
  assign push      = mic_data_valid && !fifo_full && !mic_data_retrieved;
  assign pop       = (state == ST_HDR) && tx_ready;
  // A word being pushed this cycle counts as available so a new packet starts without a bubble.
  assign have_word = !fifo_empty || push;

  mic_word_fifo #(
    .WIDTH (MIC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (mic_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mic_data_retrieved <= 1'b0;
      wait_cnt           <= '0;
      overrun            <= 1'b0;
    end else begin
      mic_data_retrieved <= push;
      if (mic_data_valid && fifo_full) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 6'd1;
        else                overrun  <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      word         <= '0;
      tx_valid     <= 1'b0;
      tx_byte      <= '0;
      stop_pending <= 1'b0;
    end else begin
      if (record_stop) stop_pending <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (have_word) begin
            state    <= ST_HDR;
            tx_valid <= 1'b1;
            tx_byte  <= HDR_SAMPLE;
          end else if (stop_pending && !mic_data_valid) begin
            state    <= ST_END;
            tx_valid <= 1'b1;
            tx_byte  <= HDR_END;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            word    <= fifo_rd;
            idx     <= '0;
            tx_byte <= ulaw_byte(fifo_rd, 2'd0);
            state   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (tx_ready) begin
            if (idx == 2'd3) begin
              if (have_word) begin
                state   <= ST_HDR;
                tx_byte <= HDR_SAMPLE;
              end else begin
                state    <= ST_IDLE;
                tx_valid <= 1'b0;
                tx_byte  <= '0;
              end
            end else begin
              idx     <= idx + 2'd1;
              tx_byte <= ulaw_byte(word, idx + 2'd1);
            end
          end
        end
        ST_END: begin
          if (tx_ready) begin
            state        <= ST_IDLE;
            tx_valid     <= 1'b0;
            tx_byte      <= '0;
            stop_pending <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mic_packet_sender.sv
// Bench for mic_packet_sender: stream-level reference model checked every cycle, plus directed scenarios.
module tb_mic_packet_sender;
  localparam int DEPTH = 4;
  localparam logic [7:0] HS = 8'hC7;
  localparam logic [7:0] HE = 8'hC8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mic_data = '0;
  logic        mic_data_valid = 1'b0;
  logic        mic_data_retrieved;
  logic        record_stop;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [2:0]  fifo_level;
  logic        overrun;

  always #5 clk = ~clk;

  mic_packet_sender #(
    .FIFO_DEPTH (DEPTH),
    .HDR_SAMPLE (HS),
    .HDR_END    (HE)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mic_data           (mic_data),
    .mic_data_valid     (mic_data_valid),
    .mic_data_retrieved (mic_data_retrieved),
    .record_stop        (record_stop),
    .tx_byte            (tx_byte),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .fifo_level         (fifo_level),
    .overrun            (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w >> (8 * (3 - k));
    return t[7:0];
  endfunction

  // Upstream source: presents words in order, drops valid after each acknowledge.
  logic [31:0] feed_q[$];
  int          feed_idx = 0;
  bit          feed_rand = 0;
  int          gap = 0;

  always @(posedge clk) begin
    #1;
    if (mic_data_valid && mic_data_retrieved === 1'b1) begin
      mic_data_valid = 1'b0;
      feed_idx++;
      gap = feed_rand ? int'($urandom_range(0, 3)) : 0;
    end else if (!mic_data_valid) begin
      if (gap > 0) gap--;
      else if (feed_idx < feed_q.size()) begin
        mic_data       = feed_q[feed_idx];
        mic_data_valid = 1'b1;
      end
    end
  end

  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b0;
      2:       tx_ready = ($urandom_range(0, 9) < 7);
      3:       tx_ready = ~tx_ready;
      default: tx_ready = 1'b1;
    endcase
  end

  // Reference model: words buffered, packet in progress, pending stop, wait streak.
  logic [31:0] m_words[$];
  logic [31:0] m_cur = '0;
  int          m_pos = 0;
  bit          m_stop = 0, m_end_offer = 0, m_ret = 0, m_ovr = 0;
  bit          m_live = 0, m_just_reset = 0;
  int          m_run = 0;
  logic [7:0]  txlog[$];
  int          txcyc[$];
  int          cyc = 0;
  int          ret_cnt = 0;
  int          end_cnt = 0;

  always @(negedge clk) begin
    logic [7:0] exp_b;
    bit busy, xfer, full_b, push_b, end_x;
    cyc++;
    if (m_live) begin
      busy = (m_pos != 0) || (m_words.size() != 0);
      if (!busy && m_stop && !m_end_offer && tx_valid === 1'b1) m_end_offer = 1;
      if (m_end_offer)    exp_b = HE;
      else if (m_pos == 0) exp_b = HS;
      else                 exp_b = byte_of(m_cur, m_pos - 1);
      if (busy || m_end_offer) chk("tx_valid_busy", 32'(tx_valid), 1);
      else if (!m_stop)        chk("tx_valid_idle", 32'(tx_valid), 0);
      if (tx_valid === 1'b1 && (busy || m_end_offer)) chk("tx_byte", 32'(tx_byte), 32'(exp_b));
      if (m_just_reset) chk("tx_byte_rst", 32'(tx_byte), 0);
      chk("retrieved", 32'(mic_data_retrieved), 32'(m_ret));
      chk("fifo_level", 32'(fifo_level), m_words.size());
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
    if (rst === 1'b1) begin
      m_words.delete();
      m_pos = 0; m_stop = 0; m_end_offer = 0; m_ret = 0; m_ovr = 0; m_run = 0;
      m_live = 1; m_just_reset = 1;
    end else if (m_live) begin
      m_just_reset = 0;
      xfer   = (tx_valid === 1'b1) && (tx_ready === 1'b1);
      full_b = (m_words.size() == DEPTH);
      push_b = (mic_data_valid === 1'b1) && !full_b && !m_ret;
      end_x  = 0;
      if (xfer) begin
        txlog.push_back(tx_byte);
        txcyc.push_back(cyc);
        if (m_end_offer) begin
          m_end_offer = 0; m_stop = 0; end_x = 1; end_cnt++;
        end else if (m_pos == 0) begin
          if (m_words.size() != 0) begin
            m_cur = m_words.pop_front();
            m_pos = 1;
          end
        end else begin
          m_pos = (m_pos == 4) ? 0 : m_pos + 1;
        end
      end
      if (record_stop === 1'b1 && !end_x) m_stop = 1;
      if (mic_data_valid === 1'b1 && full_b) m_run++;
      else m_run = 0;
      if (m_run >= 64) m_ovr = 1;
      if (push_b) begin
        m_words.push_back(mic_data);
        ret_cnt++;
      end
      m_ret = push_b;
    end
  end

  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_pkt(input logic [31:0] w);
    exp_q.push_back(HS);
    for (int k = 0; k < 4; k++) exp_q.push_back(byte_of(w, k));
  endtask

  task automatic check_seq(input int base, input string nm);
    chk({nm, "_len"}, txlog.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < txlog.size()) chk(nm, 32'(txlog[base + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      tick();
      if (feed_idx == feed_q.size() && !mic_data_valid && m_words.size() == 0 &&
          m_pos == 0 && !m_stop && !m_end_offer && tx_valid === 1'b0) quiet++;
      else quiet = 0;
    end
    chk("idle_reached", 32'(quiet >= 3), 1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int i = 0;
    while (txlog.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk("log_reached", 32'(txlog.size() >= n), 1);
  endtask

  task automatic stop_pulse();
    record_stop = 1'b1;
    tick();
    record_stop = 1'b0;
  endtask

  initial begin
    int base, r0, e0, n0, i;
    logic [31:0] w5[5];
    rst = 1'b1;
    record_stop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single word, first-byte latency
    base = txlog.size(); r0 = ret_cnt;
    feed_q.push_back(32'h11223344);
    i = 0;
    while (mic_data_retrieved !== 1'b1 && i < 50) begin tick(); i++; end
    chk("ret_seen", 32'(mic_data_retrieved), 1);
    chk("lat_valid", 32'(tx_valid), 1);
    chk("lat_hdr", 32'(tx_byte), 32'h0000_00C7);
    wait_idle(200);
    exp_q = '{8'hC7, 8'h11, 8'h22, 8'h33, 8'h44};
    check_seq(base, "single_seq");
    chk("single_pulses", ret_cnt - r0, 1);
    chk("single_level", 32'(fifo_level), 0);

    // five words against a stalled transmitter
    ready_mode = 0;
    base = txlog.size(); r0 = ret_cnt;
    w5 = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
    foreach (w5[k]) feed_q.push_back(w5[k]);
    repeat (30) tick();
    chk("full_pulses", ret_cnt - r0, 4);
    chk("full_level", 32'(fifo_level), 4);
    chk("fifth_held", 32'(mic_data_valid), 1);
    chk("full_offer", 32'(tx_byte), 32'h0000_00C7);
    ready_mode = 1;
    wait_idle(300);
    foreach (w5[k]) expect_pkt(w5[k]);
    check_seq(base, "five_seq");
    if (txlog.size() >= base + 25) chk("five_no_gap", txcyc[base + 24] - txcyc[base], 24);

    // stalls on alternate cycles
    ready_mode = 3;
    base = txlog.size();
    feed_q.push_back(32'hA5A55A5A);
    wait_idle(300);
    exp_q = '{8'hC7, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
    check_seq(base, "toggle_seq");

    // stop mid-packet with a second word queued, then a redundant stop
    ready_mode = 0;
    base = txlog.size(); e0 = end_cnt;
    feed_q.push_back(32'hCAFEBABE);
    feed_q.push_back(32'hDEADBEEF);
    repeat (12) tick();
    chk("stop_pre_level", 32'(fifo_level), 2);
    ready_mode = 1;
    wait_log(base + 2, 50);
    chk("stop_mid_level", 32'(fifo_level), 1);
    stop_pulse();
    tick();
    stop_pulse();
    wait_idle(300);
    repeat (10) tick();
    exp_q = '{8'hC7, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hC7, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC8};
    check_seq(base, "stop_seq");
    chk("stop_one_end", end_cnt - e0, 1);

    // back-pressure long enough to trip the sticky overrun flag
    ready_mode = 0;
    for (int k = 0; k < 5; k++) feed_q.push_back($urandom());
    repeat (12) tick();
    chk("ovr_level", 32'(fifo_level), 4);
    repeat (30) tick();
    chk("ovr_early", 32'(overrun), 0);
    repeat (40) tick();
    chk("ovr_set", 32'(overrun), 1);
    ready_mode = 1;
    wait_idle(300);
    chk("ovr_sticky", 32'(overrun), 1);
    rst = 1'b1;
    tick();
    chk("ovr_rst", 32'(overrun), 0);
    rst = 1'b0;
    tick();

    // reset mid-packet with a stop pending
    ready_mode = 0;
    base = txlog.size();
    feed_q.push_back(32'h13579BDF);
    feed_q.push_back(32'h2468ACE0);
    repeat (12) tick();
    stop_pulse();
    ready_mode = 1;
    wait_log(base + 3, 50);
    rst = 1'b1;
    tick();
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    rst = 1'b0;
    n0 = txlog.size(); e0 = end_cnt;
    repeat (20) tick();
    chk("rst_quiet", txlog.size() - n0, 0);
    chk("rst_no_end", end_cnt - e0, 0);

    // randomized traffic with random stalls, gaps and stop pulses
    ready_mode = 2;
    feed_rand = 1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 15; k++) feed_q.push_back($urandom());
      i = 0;
      while (feed_idx < feed_q.size() && i < 3000) begin
        record_stop = ($urandom_range(0, 39) == 0);
        tick();
        i++;
      end
      record_stop = 1'b0;
      chk("rand_fed", 32'(feed_idx == feed_q.size()), 1);
      stop_pulse();
      wait_idle(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mic_packet_sender.md
MIC_PACKET_SENDER -- requirements
Module: mic_packet_sender

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit mic words buffered (power of two, 2..16).
REQ-002 Parameter HDR_SAMPLE, default 8'hC7, header byte preceding each 4-sample payload.
REQ-003 Parameter HDR_END, default 8'hC8, single-byte end-of-recording marker.
REQ-004 Ports (name  direction  width  meaning):
REQ-005 clk  in  1  monitor clock; one clock domain; rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 mic_data  in  32  four packed u-law bytes, [31:24] oldest sample.
REQ-008 mic_data_valid  in  1  mic_data holds an unconsumed word.
REQ-009 mic_data_retrieved  out  1  one-cycle pulse acknowledging consumption of mic_data.
REQ-010 record_stop  in  1  one-cycle pulse: recording ended, flush and emit end marker.
REQ-011 tx_byte  out  8  byte offered to monitor-bus transmitter.
REQ-012 tx_valid  out  1  tx_byte is valid.
REQ-013 tx_ready  in  1  transmitter accepts tx_byte this cycle.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-015 overrun  out  1  sticky: a word was waiting while FIFO full for 64+ consecutive cycles.

Function
REQ-016 Ingest: mic_data_retrieved SHALL pulse high for exactly one cycle when mic_data_valid=1, FIFO not full, and mic_data_retrieved was 0 the previous cycle; mic_data is written to the FIFO in that same cycle.
REQ-017 Upstream drops valid one cycle after the pulse; the block SHALL NOT pulse twice for one word (previous-cycle guard in REQ-016 enforces this).
REQ-018 FIFO full: no pulse; word stays held upstream (back-pressure), no data loss inside this block.
REQ-019 Byte transfer occurs only on a cycle with tx_valid=1 and tx_ready=1; while tx_valid=1 and tx_ready=0, tx_byte SHALL hold stable.
REQ-020 FSM states: IDLE, HDR, PAYLOAD (2-bit byte index 0..3), END.
REQ-021 IDLE -> HDR when FIFO non-empty; END has priority only when FIFO empty and stop pending.
REQ-022 HDR: tx_byte=HDR_SAMPLE; on transfer pop FIFO word into shift register, index=0, -> PAYLOAD.
REQ-023 PAYLOAD: tx_byte=word[31-8*index -: 8]; on transfer index+1; after index 3 transfer -> HDR if FIFO non-empty else IDLE (back-to-back packets, no idle gap).
REQ-024 tx_valid SHALL be 1 in HDR, PAYLOAD, END; 0 in IDLE.
REQ-025 record_stop sets a stop_pending flag; END entered from IDLE when stop_pending=1 and FIFO empty and mic_data_valid=0.
REQ-026 END: tx_byte=HDR_END; on transfer clear stop_pending, -> IDLE.
REQ-027 record_stop during HDR/PAYLOAD or with data buffered: current and all buffered packets complete first, then END.
REQ-028 Second record_stop while pending: no additional END.
REQ-029 Simultaneous FIFO push and pop in one cycle: fifo_level unchanged, both succeed.
REQ-030 overrun: 6-bit counter increments while mic_data_valid=1 and FIFO full, clears otherwise; overrun set when counter saturates at 63, cleared only by rst.
REQ-031 Latency: word accepted into empty FIFO with IDLE FSM and tx_ready=1 produces HDR on tx_byte the cycle after the push.

Reset
REQ-032 On rst=1: FSM=IDLE, FIFO empty, fifo_level=0, tx_valid=0, tx_byte=8'h00, mic_data_retrieved=0, stop_pending=0, overrun=0, counter=0.
REQ-033 rst mid-packet SHALL abort the packet without emitting remaining bytes or END; buffered words are discarded.

Structure
REQ-034 Shared package mic_pkg holds HDR_SAMPLE/HDR_END defaults, FSM state enumeration, and the u-law byte width constant.
REQ-035 One sub-module mic_word_fifo: synchronous FIFO, parameterised width/depth, push/pop/full/empty/level.

Verification
REQ-036 Single word 32'h11223344, tx_ready=1 -> bytes C7,11,22,33,44; one retrieved pulse; fifo_level returns 0.
REQ-037 Five words with tx_ready=0 -> four retrieved pulses, fifo_level=4, fifth held; tx_ready=1 -> 20 bytes then fifth packet, five packets in order, no gaps.
REQ-038 tx_ready toggling every cycle during word 32'hA5A55A5A -> tx_byte stable while stalled; sequence C7,A5,A5,5A,5A.
REQ-039 record_stop at PAYLOAD index 1 with one word buffered -> both packets complete, then single C8; second stop pulse adds nothing.
REQ-040 mic_data_valid held with FIFO full and tx_ready=0 for 70 cycles -> overrun=1 at cycle 64, stays 1 until rst.
REQ-041 rst asserted at PAYLOAD index 2 -> next cycle tx_valid=0, fifo_level=0; no C8 emitted afterwards.
